// File: rtl/column_reader.sv
// Read side of the 8x8 IDCT transpose stage.
// Walks the 64-entry row buffer (column-major or linear) and streams each
// coefficient through a single output register over a valid/ready handshake.
module column_reader #(
    parameter int unsigned DATA_W    = 16,
    parameter bit          TRANSPOSE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              buf_read_enable,
    output logic [5:0]        buf_index,
    input  logic [DATA_W-1:0] buf_data,
    output logic [DATA_W-1:0] col_data,
    output logic              col_valid,
    input  logic              col_ready,
    output logic              col_last,
    output logic              blk_last
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_t;

    state_t     state_q;
    logic [5:0] cnt_q;
    logic       fire;
    logic       accept;

    // Read strobe and address: index follows the counter and holds while stalled.
    always_comb begin
        fire            = (state_q == StRead) && (!col_valid || col_ready);
        accept          = col_valid && col_ready;
        buf_read_enable = fire;
        if (TRANSPOSE) begin
            // outer counter bits pick the column, inner bits the row (row fastest)
            buf_index = {cnt_q[2:0], cnt_q[5:3]};
        end else begin
            buf_index = cnt_q;
        end
    end

    // Sequencer, read counter and the single output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            col_data  <= '0;
            col_valid <= 1'b0;
            col_last  <= 1'b0;
            blk_last  <= 1'b0;
        end else begin
            done <= 1'b0;

            if (fire) begin
                col_data  <= buf_data;
                col_valid <= 1'b1;
                col_last  <= (cnt_q[2:0] == 3'd7);
                blk_last  <= (cnt_q == 6'd63);
                cnt_q     <= cnt_q + 6'd1;
            end else if (accept) begin
                col_valid <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    // A start landing in the done cycle is ignored.
                    if (start && !done) begin
                        state_q <= StRead;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                StRead: begin
                    if (fire && (cnt_q == 6'd63)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // busy stays high through the done cycle
                    if (accept) begin
                        state_q <= StIdle;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
